// File: rtl/float_pkg.sv
// ============================================================================
// Module : float_pkg
// Shared widths, exponent limits and normalization FSM state encoding for
// the single-precision float adder pipeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package float_pkg;

  localparam int FRACT_W = 27;  // hidden + 23 mantissa + G/R/S
  localparam int EXP_W   = 8;

  localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_MIN_NORM = 8'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage : float_pkg

`default_nettype wire

// File: rtl/contador_zeros_27.sv
// ============================================================================
// Module : contador_zeros_27
// Combinational leading-zero counter over a 27-bit value.
//   value : in  27  operand, bit 26 is the most significant
//   count : out 5   number of leading zeros (27 when value is zero)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_zeros_27 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit overwrite any lower one.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) begin
        count = 5'(26 - i);
      end
    end
  end

endmodule : contador_zeros_27

`default_nettype wire

// File: rtl/normalizacao_seq.sv
// ============================================================================
// Module : normalizacao_seq
// Sequential normalization stage of the single-precision float adder.
// Takes the raw 28-bit sum and tentative exponent, produces a normalized
// 27-bit fraction (hidden bit at [26], G/R/S at [2:0]) and adjusted exponent.
// Start/done handshake; left shift is one bit per cycle unless NORM_LZC_EN
// is defined, in which case the whole left shift happens in one cycle using
// a leading-zero counter (results identical, only latency differs).
//
// Ports:
//   clock     in   1   rising-edge clock
//   reset     in   1   asynchronous active-high reset
//   start     in   1   request, sampled only in IDLE
//   fract_in  in   28  raw sum ([27] carry, [26] hidden, [2:0] G/R/S)
//   exp_in    in   8   tentative biased exponent
//   fract_out out  27  normalized fraction (registered)
//   exp_out   out  8   adjusted exponent (registered)
//   done      out  1   one-cycle completion pulse
//   busy      out  1   high in every state except IDLE
//   zero      out  1   exact-zero result
//   underflow out  1   normalization stopped at the exponent floor
//   overflow  out  1   right shift reached exponent 255
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module normalizacao_seq #(
  parameter int FRACT_W = 27,
  parameter int EXP_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [FRACT_W:0]   fract_in,
  input  logic [EXP_W-1:0]   exp_in,
  output logic [FRACT_W-1:0] fract_out,
  output logic [EXP_W-1:0]   exp_out,
  output logic               done,
  output logic               busy,
  output logic               zero,
  output logic               underflow,
  output logic               overflow
);

  import float_pkg::*;

  norm_state_t        r_state;
  logic [FRACT_W:0]   r_frac;
  logic [EXP_W-1:0]   r_exp;
  logic [FRACT_W-1:0] r_fract_out;
  logic [EXP_W-1:0]   r_exp_out;
  logic               r_done;
  logic               r_busy;
  logic               r_zero;
  logic               r_underflow;
  logic               r_overflow;

  // Next-step values of the working registers while in NORM.
  logic               w_finish;
  logic [FRACT_W:0]   w_frac_next;
  logic [EXP_W-1:0]   w_exp_next;
  logic [EXP_W-1:0]   w_exp_inc;
  logic               w_zero;
  logic               w_under;
  logic               w_over;

  // Saturating increment: 255 stays at 255 rather than wrapping.
  assign w_exp_inc = (r_exp == EXP_MAX) ? EXP_MAX : r_exp + 1'b1;

`ifdef NORM_LZC_EN
  logic [4:0]       w_lzc;
  logic [4:0]       w_shamt;
  logic [EXP_W-1:0] w_lim;
  logic             w_lzc_over;

  contador_zeros_27 u_lzc (
    .value (r_frac[FRACT_W-1:0]),
    .count (w_lzc)
  );

  // The exponent may drop to 1 at most; exponents already at or below 1
  // allow no shift at all.
  assign w_lim      = (r_exp > EXP_MIN_NORM) ? r_exp - 1'b1 : '0;
  assign w_lzc_over = EXP_W'(w_lzc) > w_lim;
  // When clamped, w_lim < lzc <= 26 so its low five bits carry the value.
  assign w_shamt    = w_lzc_over ? w_lim[4:0] : w_lzc;
`endif

  always_comb begin
    w_finish    = 1'b0;
    w_frac_next = r_frac;
    w_exp_next  = r_exp;
    w_zero      = 1'b0;
    w_under     = 1'b0;
    w_over      = 1'b0;
    if (r_frac[FRACT_W]) begin
      // Carry out: shift right once, folding the dropped bit into sticky.
      w_frac_next = {1'b0, r_frac[FRACT_W:2], r_frac[1] | r_frac[0]};
      w_exp_next  = w_exp_inc;
      w_over      = (w_exp_inc == EXP_MAX);
      w_finish    = 1'b1;
    end else if (r_frac == '0) begin
      w_exp_next = '0;
      w_zero     = 1'b1;
      w_finish   = 1'b1;
    end else if (r_frac[FRACT_W-1]) begin
      w_finish = 1'b1;
    end else begin
`ifdef NORM_LZC_EN
      // Shift amount never exceeds lzc, so bit 27 stays clear.
      w_frac_next = r_frac << w_shamt;
      w_exp_next  = r_exp - EXP_W'(w_shamt);
      w_under     = w_lzc_over;
      w_finish    = 1'b1;
`else
      if (r_exp <= EXP_MIN_NORM) begin
        w_under  = 1'b1;
        w_finish = 1'b1;
      end else begin
        w_frac_next = {r_frac[FRACT_W-1:0], 1'b0};
        w_exp_next  = r_exp - 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_frac      <= '0;
      r_exp       <= '0;
      r_fract_out <= '0;
      r_exp_out   <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_zero      <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_frac  <= fract_in;
            r_exp   <= exp_in;
            r_busy  <= 1'b1;
            r_state <= NORM;
          end
        end
        NORM: begin
          r_frac <= w_frac_next;
          r_exp  <= w_exp_next;
          // Results are published on the edge entering DONE so they are
          // valid during the done cycle itself.
          if (w_finish) begin
            r_fract_out <= w_frac_next[FRACT_W-1:0];
            r_exp_out   <= w_exp_next;
            r_zero      <= w_zero;
            r_underflow <= w_under;
            r_overflow  <= w_over;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fract_out = r_fract_out;
  assign exp_out   = r_exp_out;
  assign done      = r_done;
  assign busy      = r_busy;
  assign zero      = r_zero;
  assign underflow = r_underflow;
  assign overflow  = r_overflow;

endmodule : normalizacao_seq

`default_nettype wire

// File: tb/tb_normalizacao_seq.sv
// ============================================================================
// Module : tb_normalizacao_seq
// Self-checking bench for normalizacao_seq: directed vectors, a behavioural
// model of the normalization result and latency, and literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_normalizacao_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [27:0] fract_in = '0;
  logic [7:0]  exp_in = '0;
  logic [26:0] fract_out;
  logic [7:0]  exp_out;
  logic        done, busy, zero, underflow, overflow;

  int checks = 0;
  int failures = 0;

  normalizacao_seq dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .fract_in  (fract_in),
    .exp_in    (exp_in),
    .fract_out (fract_out),
    .exp_out   (exp_out),
    .done      (done),
    .busy      (busy),
    .zero      (zero),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int cnt = 0;
  always @(posedge clock) cnt++;

  // Model expectations for the operation in flight.
  logic [26:0] m_frac;
  logic [7:0]  m_exp;
  logic        m_zero, m_under, m_over;
  int          m_lat;
  int          s_cyc;
  bit          armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Normalization from the rules: locate the leading one, shift it to bit 26
  // as far as the exponent floor of 1 allows.
  task automatic model(input logic [27:0] f, input logic [7:0] e);
    int p, need, avail, k;
    m_zero = 0; m_under = 0; m_over = 0; m_lat = 2;
    if (f[27]) begin
      m_frac = {f[27:2], f[1] | f[0]};
      m_exp  = (e == 8'd255) ? 8'd255 : e + 8'd1;
      m_over = (m_exp == 8'd255);
    end else if (f == 0) begin
      m_frac = '0;
      m_exp  = '0;
      m_zero = 1;
    end else begin
      p = 0;
      for (int i = 0; i < 27; i++) if (f[i]) p = i;
      need  = 26 - p;
      avail = (e > 1) ? int'(e) - 1 : 0;
      k     = (need < avail) ? need : avail;
      m_frac  = f[26:0] << k;
      m_exp   = e - 8'(k);
      m_under = (need > avail);
`ifndef NORM_LZC_EN
      m_lat = 2 + k;
`endif
    end
  endtask

  // Per-cycle compare of handshake timing and results against the model.
  always @(negedge clock) begin
    int cyc;
    if (armed) begin
      cyc = cnt - s_cyc;
      chk("done_timing", {31'd0, done}, {31'd0, cyc == m_lat});
      chk("busy_timing", {31'd0, busy}, {31'd0, (cyc >= 1) && (cyc <= m_lat)});
      if (cyc == m_lat) begin
        chk("model_fract", {5'd0, fract_out}, {5'd0, m_frac});
        chk("model_exp", {24'd0, exp_out}, {24'd0, m_exp});
        chk("model_flags", {29'd0, zero, underflow, overflow}, {29'd0, m_zero, m_under, m_over});
      end
      if (cyc >= m_lat + 1) armed = 1'b0;
    end else if (!reset && done) begin
      chk("spurious_done", {31'd0, done}, 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_fract"}, {5'd0, fract_out}, 32'd0);
    chk({tag, "_exp"}, {24'd0, exp_out}, 32'd0);
    chk({tag, "_flags"}, {29'd0, zero, underflow, overflow}, 32'd0);
  endtask

  // poke: raise start again during busy; abort_at > 0: assert reset in
  // that cycle of the operation.
  task automatic run(input logic [27:0] f, input logic [7:0] e,
                     input logic [26:0] lf, input logic [7:0] le,
                     input logic [2:0] lflags, input bit poke, input int abort_at);
    model(f, e);
    @(negedge clock);
    start = 1'b1; fract_in = f; exp_in = e; s_cyc = cnt;
    @(posedge clock);
    #1 armed = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (poke) begin
      start = 1'b1; fract_in = 28'h0000001; exp_in = 8'd30;
      @(negedge clock);
      start = 1'b0;
    end
    if (abort_at > 0) begin
      while (cnt - s_cyc < abort_at) @(negedge clock);
      #2 armed = 1'b0;
      reset = 1'b1;
      #1 check_all_zero("abort");
      @(negedge clock);
      check_all_zero("abort_hold");
      reset = 1'b0;
      return;
    end
    for (int i = 0; i < 40 && armed; i++) @(negedge clock);
    #2;
    if (armed) begin
      chk("done_timeout", 32'd0, 32'd1);
      armed = 1'b0;
    end
    chk("lit_fract", {5'd0, fract_out}, {5'd0, lf});
    chk("lit_exp", {24'd0, exp_out}, {24'd0, le});
    chk("lit_flags", {29'd0, zero, underflow, overflow}, {29'd0, lflags});
  endtask

  // flags literal order: {zero, underflow, overflow}
  initial begin
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    run(28'h8000001, 8'd127, 27'h4000001, 8'd128, 3'b000, 0, 0);
    run(28'h4000000, 8'd100, 27'h4000000, 8'd100, 3'b000, 0, 0);
    run(28'h0800000, 8'd100, 27'h4000000, 8'd97,  3'b000, 0, 0);
    run(28'h0000000, 8'd50,  27'h0000000, 8'd0,   3'b100, 0, 0);
    run(28'h0000008, 8'd3,   27'h0000020, 8'd1,   3'b010, 0, 0);
    run(28'h8000000, 8'd254, 27'h4000000, 8'd255, 3'b001, 1, 0);
    run(28'h8000003, 8'd255, 27'h4000001, 8'd255, 3'b001, 0, 0);
    run(28'h2000000, 8'd2,   27'h4000000, 8'd1,   3'b000, 0, 0);
    run(28'h0000001, 8'd1,   27'h0000001, 8'd1,   3'b010, 0, 0);
    run(28'h0000100, 8'd0,   27'h0000100, 8'd0,   3'b010, 0, 0);
    run(28'h0000001, 8'd30,  27'h4000000, 8'd4,   3'b000, 1, 0);
    run(28'h0800000, 8'd100, 27'h0000000, 8'd0,   3'b000, 0, 3);
    run(28'h0800000, 8'd100, 27'h4000000, 8'd97,  3'b000, 0, 0);
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_normalizacao_seq

`default_nettype wire
